// File: rtl/hyperram_responder_if.sv
// HyperBus link between a controller (master) and hyperram_responder (slave).
interface hyperram_responder_if;
  logic       dram_ck;
  logic       dram_cs_l;
  logic       dram_rst_l;
  logic [7:0] dram_dq_in;
  logic [7:0] dram_dq_out;
  logic       dram_dq_oe;
  logic       dram_rwds_in;
  logic       dram_rwds_out;
  logic       dram_rwds_oe;
  logic       active;

  modport master (
    output dram_ck, dram_cs_l, dram_rst_l, dram_dq_in, dram_rwds_in,
    input  dram_dq_out, dram_dq_oe, dram_rwds_out, dram_rwds_oe, active
  );

  modport slave (
    input  dram_ck, dram_cs_l, dram_rst_l, dram_dq_in, dram_rwds_in,
    output dram_dq_out, dram_dq_oe, dram_rwds_out, dram_rwds_oe, active
  );
endinterface

// File: rtl/hyperram_responder.sv
// HyperBus device-side responder backed by an internal array of 16-bit words.
// Optional HRAM_RSP_RWDS_LAT_EN: drive RWDS high during CA and double the access latency.
module hyperram_responder #(
  parameter int          ADDR_W    = 10,
  parameter int          LAT_EDGES = 22,
  parameter logic [15:0] ID0_VAL   = 16'h0C83
) (
  input  logic                clk,
  input  logic                reset,
  hyperram_responder_if.slave hram
);
  localparam int DEPTH = 1 << ADDR_W;
`ifdef HRAM_RSP_RWDS_LAT_EN
  localparam int LAT_TOTAL = 2 * LAT_EDGES;
`else
  localparam int LAT_TOTAL = LAT_EDGES;
`endif
  localparam logic [15:0]       LAT_LAST = 16'(LAT_TOTAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CA    = 3'd1;
  localparam logic [2:0] ST_LAT   = 3'd2;
  localparam logic [2:0] ST_WDATA = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;

  logic              ck_q_reg;
  logic [2:0]        state_reg;
  logic [15:0]       edge_cnt_reg;
  logic [39:0]       ca_reg;
  logic              rw_reg;
  logic              reg_space_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        dq_out_reg;
  logic              dq_oe_reg;
  logic              rwds_out_reg;
  logic              rwds_oe_reg;

  logic        ck_edge;
  logic        odd_edge;
  logic        ca_done;
  logic [47:0] ca_next;
  logic [31:0] ca_word_addr;
  logic [2:0]  ca_dest;
  logic        wr_byte_ok;
  logic [15:0] rd_word;
  logic        unused_bits;

  // Edges are ignored while the device is held in reset
  assign ck_edge      = hram.dram_rst_l && (hram.dram_ck != ck_q_reg);
  assign odd_edge     = edge_cnt_reg[0];
  assign ca_next      = {ca_reg, hram.dram_dq_in};
  assign ca_word_addr = {ca_next[44:16], ca_next[2:0]};
  assign ca_done      = (edge_cnt_reg == 16'd5);
  assign wr_byte_ok   = (state_reg == ST_WDATA) && ck_edge && !hram.dram_cs_l &&
                        !reg_space_reg && !hram.dram_rwds_in;
  assign unused_bits  = ^{ca_next[45], ca_next[15:3], ca_word_addr[31:ADDR_W]};

  always_comb begin
    ca_dest = ST_LAT;
    if (!ca_next[47] && ca_next[46])
      ca_dest = ST_WDATA;
    else if (LAT_TOTAL == 0)
      ca_dest = ca_next[47] ? ST_RDATA : ST_WDATA;
  end

  // Upper byte lives in lane 1 (even data edges), lower byte in lane 0 (odd edges)
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_byte_reg;
    logic       we;

    assign we = wr_byte_ok && (odd_edge == (gi == 0));

    always_ff @(posedge clk) begin
      if (we)
        mem[addr_reg] <= hram.dram_dq_in;
      rd_byte_reg <= mem[addr_reg];
    end
  end

  assign rd_word = reg_space_reg ? ID0_VAL : {g_lane[1].rd_byte_reg, g_lane[0].rd_byte_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ck_q_reg      <= 1'b0;
      state_reg     <= ST_IDLE;
      edge_cnt_reg  <= '0;
      ca_reg        <= '0;
      rw_reg        <= 1'b0;
      reg_space_reg <= 1'b0;
      addr_reg      <= '0;
      dq_out_reg    <= '0;
      dq_oe_reg     <= 1'b0;
      rwds_out_reg  <= 1'b0;
      rwds_oe_reg   <= 1'b0;
    end else begin
      ck_q_reg <= hram.dram_ck;
      // A cs_l rise beats any edge arriving in the same cycle
      if (!hram.dram_rst_l || hram.dram_cs_l) begin
        state_reg    <= ST_IDLE;
        dq_out_reg   <= '0;
        dq_oe_reg    <= 1'b0;
        rwds_out_reg <= 1'b0;
        rwds_oe_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_reg    <= ST_CA;
            edge_cnt_reg <= '0;
            ca_reg       <= '0;
`ifdef HRAM_RSP_RWDS_LAT_EN
            rwds_oe_reg  <= 1'b1;
            rwds_out_reg <= 1'b1;
`endif
          end
          ST_CA: begin
            if (ck_edge) begin
              ca_reg       <= ca_next[39:0];
              edge_cnt_reg <= edge_cnt_reg + 16'd1;
              if (ca_done) begin
                rw_reg        <= ca_next[47];
                reg_space_reg <= ca_next[46];
                addr_reg      <= ca_word_addr[ADDR_W-1:0];
                state_reg     <= ca_dest;
                edge_cnt_reg  <= '0;
`ifdef HRAM_RSP_RWDS_LAT_EN
                if (ca_dest != ST_RDATA)
                  rwds_oe_reg <= 1'b0;
`endif
              end
            end
          end
          ST_LAT: begin
            if (ck_edge) begin
              if (edge_cnt_reg == LAT_LAST) begin
                state_reg    <= rw_reg ? ST_RDATA : ST_WDATA;
                edge_cnt_reg <= '0;
              end else begin
                edge_cnt_reg <= edge_cnt_reg + 16'd1;
              end
            end
          end
          ST_WDATA: begin
            if (ck_edge) begin
              edge_cnt_reg <= edge_cnt_reg + 16'd1;
              if (odd_edge)
                addr_reg <= addr_reg + ADDR_ONE;
            end
          end
          ST_RDATA: begin
            dq_oe_reg   <= 1'b1;
            rwds_oe_reg <= 1'b1;
            if (ck_edge) begin
              dq_out_reg   <= odd_edge ? rd_word[7:0] : rd_word[15:8];
              rwds_out_reg <= !odd_edge;
              edge_cnt_reg <= edge_cnt_reg + 16'd1;
              if (odd_edge)
                addr_reg <= addr_reg + ADDR_ONE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign hram.dram_dq_out   = dq_out_reg;
  assign hram.dram_dq_oe    = dq_oe_reg;
  assign hram.dram_rwds_out = rwds_out_reg;
  assign hram.dram_rwds_oe  = rwds_oe_reg;
  assign hram.active        = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_hyperram_responder.sv
// Scoreboard bench for hyperram_responder: a default-size instance plus an ADDR_W=4 instance for wrap.
module tb_hyperram_responder;
  localparam int LAT = 22;

  logic clk;
  logic reset;
  logic sel_b;
  int   compared;
  int   mismatched;

  logic [9:0] exp_q[$];
  logic [9:0] exp_v;
  logic [9:0] got_v;
  logic       prev_rwds;

  hyperram_responder_if hif_a();
  hyperram_responder_if hif_b();

  assign hif_b.dram_ck      = hif_a.dram_ck;
  assign hif_b.dram_cs_l    = hif_a.dram_cs_l;
  assign hif_b.dram_rst_l   = hif_a.dram_rst_l;
  assign hif_b.dram_dq_in   = hif_a.dram_dq_in;
  assign hif_b.dram_rwds_in = hif_a.dram_rwds_in;

  hyperram_responder #(.ADDR_W(10), .LAT_EDGES(LAT), .ID0_VAL(16'h0C83)) dut_a (
    .clk   (clk),
    .reset (reset),
    .hram  (hif_a)
  );

  hyperram_responder #(.ADDR_W(4), .LAT_EDGES(LAT), .ID0_VAL(16'h0C83)) dut_b (
    .clk   (clk),
    .reset (reset),
    .hram  (hif_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       m_dq_oe;
  logic       m_rwds_oe;
  logic       m_rwds_out;
  logic [7:0] m_dq_out;
  assign m_dq_oe    = sel_b ? hif_b.dram_dq_oe    : hif_a.dram_dq_oe;
  assign m_rwds_oe  = sel_b ? hif_b.dram_rwds_oe  : hif_a.dram_rwds_oe;
  assign m_rwds_out = sel_b ? hif_b.dram_rwds_out : hif_a.dram_rwds_out;
  assign m_dq_out   = sel_b ? hif_b.dram_dq_out   : hif_a.dram_dq_out;

  // Monitor: every new read byte flips rwds_out while DQ is driven
  initial prev_rwds = 1'b0;
  always @(negedge clk) begin
    if (m_dq_oe && (m_rwds_out != prev_rwds)) begin
      got_v = {m_rwds_oe, m_rwds_out, m_dq_out};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL rd_byte: got %h with no byte expected", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          mismatched++;
          $display("FAIL rd_byte: got oe/rwds/dq=%h expected %h", got_v, exp_v);
        end
      end
    end
    prev_rwds <= m_dq_oe ? m_rwds_out : 1'b0;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ck_toggle(input logic [7:0] dq, input logic rwds);
    @(negedge clk);
    hif_a.dram_dq_in   = dq;
    hif_a.dram_rwds_in = rwds;
    hif_a.dram_ck      = ~hif_a.dram_ck;
    tick(3);
  endtask

  function automatic logic [47:0] mk_ca(input logic rw, input logic rs, input logic [31:0] addr);
    mk_ca = {rw, rs, 1'b1, addr[31:3], 13'd0, addr[2:0]};
  endfunction

  task automatic start(input logic [47:0] ca);
    @(negedge clk);
    hif_a.dram_cs_l = 1'b0;
    for (int i = 0; i < 6; i++)
      ck_toggle(ca[47-8*i -: 8], 1'b0);
  endtask

  task automatic lat_edges();
    repeat (LAT) ck_toggle(8'h00, 1'b0);
  endtask

  task automatic end_tx();
    @(negedge clk);
    hif_a.dram_cs_l = 1'b1;
    tick(2);
  endtask

  task automatic mem_write(input logic [31:0] addr, input int n, input logic [47:0] words,
                           input logic [5:0] masks);
    $display("write addr=%h words=%0d data=%h mask=%b", addr, n, words, masks);
    start(mk_ca(1'b0, 1'b0, addr));
    lat_edges();
    for (int i = 0; i < n; i++) begin
      ck_toggle(words[47-16*i -: 8], masks[5-2*i]);
      ck_toggle(words[39-16*i -: 8], masks[4-2*i]);
    end
    end_tx();
  endtask

  task automatic mem_read(input logic [31:0] addr, input int n, input logic [47:0] words,
                          input logic reg_sp);
    logic [15:0] w;
    $display("read  addr=%h words=%0d reg=%0d expect=%h", addr, n, reg_sp, words);
    start(mk_ca(1'b1, reg_sp, addr));
    lat_edges();
    for (int i = 0; i < n; i++) begin
      w = words[47-16*i -: 16];
      exp_q.push_back({1'b1, 1'b1, w[15:8]});
      ck_toggle(8'h00, 1'b0);
      exp_q.push_back({1'b1, 1'b0, w[7:0]});
      ck_toggle(8'h00, 1'b0);
    end
    end_tx();
  endtask

  function automatic logic [15:0] outs_a();
    outs_a = {4'd0, hif_a.active, hif_a.dram_dq_oe, hif_a.dram_rwds_oe,
              hif_a.dram_rwds_out, hif_a.dram_dq_out};
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    sel_b      = 1'b0;
    reset      = 1'b1;
    hif_a.dram_ck      = 1'b0;
    hif_a.dram_cs_l    = 1'b1;
    hif_a.dram_rst_l   = 1'b1;
    hif_a.dram_dq_in   = 8'h00;
    hif_a.dram_rwds_in = 1'b0;
    tick(3);
    check("reset_outputs", outs_a(), 16'h0000);
    reset = 1'b0;
    tick(2);

    // Basic write then read
    mem_write(32'h010, 1, 48'hA55A_0000_0000, 6'b000000);
    mem_read (32'h010, 1, 48'hA55A_0000_0000, 1'b0);

    // Byte mask on the upper byte
    mem_write(32'h020, 1, 48'h1234_0000_0000, 6'b000000);
    mem_write(32'h020, 1, 48'hFFFF_0000_0000, 6'b100000);
    mem_read (32'h020, 1, 48'h12FF_0000_0000, 1'b0);

    // Register read
    mem_read(32'h000, 1, 48'h0C83_0000_0000, 1'b1);

    // Zero-latency register write leaves memory alone
    $display("regwr addr=010 data=DEAD");
    start(mk_ca(1'b0, 1'b1, 32'h010));
    ck_toggle(8'hDE, 1'b0);
    ck_toggle(8'hAD, 1'b0);
    @(negedge clk);
    check("regwr_active_before", {15'd0, hif_a.active}, 16'h0001);
    hif_a.dram_cs_l = 1'b1;
    @(negedge clk);
    check("regwr_active_after", {15'd0, hif_a.active}, 16'h0000);
    tick(2);
    mem_read(32'h010, 1, 48'hA55A_0000_0000, 1'b0);

    // Abort after one data edge
    $display("abort addr=010 after one byte");
    start(mk_ca(1'b1, 1'b0, 32'h010));
    lat_edges();
    exp_q.push_back({1'b1, 1'b1, 8'hA5});
    ck_toggle(8'h00, 1'b0);
    @(negedge clk);
    hif_a.dram_cs_l = 1'b1;
    @(negedge clk);
    check("abort_outputs", {13'd0, hif_a.active, hif_a.dram_dq_oe, hif_a.dram_rwds_oe}, 16'h0000);
    tick(2);
    mem_read(32'h020, 1, 48'h12FF_0000_0000, 1'b0);

    // Async reset during latency
    $display("reset during latency addr=010");
    start(mk_ca(1'b1, 1'b0, 32'h010));
    repeat (5) ck_toggle(8'h00, 1'b0);
    check("lat_active", {15'd0, hif_a.active}, 16'h0001);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("lat_reset_outputs", outs_a(), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    hif_a.dram_cs_l = 1'b1;
    tick(2);

    // Device reset mid-write: second word must not land
    mem_write(32'h030, 2, 48'h0000_0000_0000, 6'b000000);
    $display("rst_l pulse during write addr=030");
    start(mk_ca(1'b0, 1'b0, 32'h030));
    lat_edges();
    ck_toggle(8'hAB, 1'b0);
    ck_toggle(8'hCD, 1'b0);
    @(negedge clk);
    hif_a.dram_rst_l = 1'b0;
    @(negedge clk);
    check("rst_l_idle", {13'd0, hif_a.active, hif_a.dram_dq_oe, hif_a.dram_rwds_oe}, 16'h0000);
    ck_toggle(8'h55, 1'b0);
    ck_toggle(8'h55, 1'b0);
    @(negedge clk);
    hif_a.dram_cs_l = 1'b1;
    @(negedge clk);
    hif_a.dram_rst_l = 1'b1;
    tick(2);
    mem_read(32'h030, 2, 48'hABCD_0000_0000, 1'b0);

    // Address wrap on the ADDR_W=4 instance
    sel_b = 1'b1;
    tick(2);
    mem_write(32'h00F, 3, 48'h1111_2222_3333, 6'b000000);
    mem_read (32'h00F, 3, 48'h1111_2222_3333, 1'b0);
    mem_read (32'h000, 1, 48'h2222_0000_0000, 1'b0);
    mem_read (32'h001, 1, 48'h3333_0000_0000, 1'b0);

    tick(5);
    check("rd_queue_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
